// File: rtl/shift_buffer_sequencer.sv
// shift_buffer_sequencer: command-sequenced fill / hold / drain controller
// around a DEPTH x WIDTH shift buffer with valid/ready on both sides.
module shift_buffer_sequencer #(
   parameter int unsigned DEPTH = 10,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_fill,
   input  logic [3:0]       fill_len,
   input  logic             cmd_drain,
   input  logic             abort,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       count,
   output logic [1:0]       state,
   output logic             done,
   output logic             err
);

   localparam int unsigned IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  DEPTH_L = 4'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t           st;
   logic [3:0]       target;
   logic [WIDTH-1:0] mem [DEPTH];

   logic in_fire;
   logic out_fire;
   logic len_ok;

   // Handshake qualifiers and output decodes, all from registered state only
   assign in_ready  = (st == S_FILL);
   assign out_valid = (st == S_DRAIN) && (count != 4'd0);
   assign out_data  = mem[0];
   assign state     = st;
   assign in_fire   = in_ready && in_valid;
   assign out_fire  = out_valid && out_ready;
   assign len_ok    = (fill_len != 4'd0) && (fill_len <= DEPTH_L);

   // Sequencer: state, occupancy, buffer contents and done/err pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         st     <= S_IDLE;
         count  <= 4'd0;
         target <= 4'd0;
         done   <= 1'b0;
         err    <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (abort && (st != S_IDLE)) begin
            // abort outranks any same-cycle handshake or command
            st    <= S_IDLE;
            count <= 4'd0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         end else begin
            case (st)
               S_IDLE: begin
                  if (cmd_fill) begin
                     if (len_ok) begin
                        target <= fill_len;
                        count  <= 4'd0;
                        st     <= S_FILL;
                     end else begin
                        err <= 1'b1;
                     end
                  end else if (cmd_drain) begin
                     err <= 1'b1;
                  end
               end
               S_FILL: begin
                  if (cmd_fill || cmd_drain) err <= 1'b1;
                  if (in_fire) begin
                     mem[IDXW'(count)] <= in_data;
                     count             <= count + 4'd1;
                     if ((count + 4'd1) == target) begin
                        st   <= S_HOLD;
                        done <= 1'b1;
                     end
                  end
               end
               S_HOLD: begin
                  // drain wins over a simultaneous fill request
                  if (cmd_drain) begin
                     st <= S_DRAIN;
                  end else if (cmd_fill) begin
                     err <= 1'b1;
                  end
               end
               S_DRAIN: begin
                  if (cmd_fill || cmd_drain) err <= 1'b1;
                  if (out_fire) begin
                     for (int i = 0; i < int'(DEPTH) - 1; i++) mem[i] <= mem[i+1];
                     mem[DEPTH-1] <= '0;
                     count        <= count - 4'd1;
                     if (count == 4'd1) begin
                        st   <= S_IDLE;
                        done <= 1'b1;
                     end
                  end
               end
               default: st <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/shift_buffer_sequencer.md
Name: shift_buffer_sequencer

Overview:
Command-driven controller that owns a DEPTH x WIDTH byte shift buffer. It sequences a fill phase, a hold phase and a drain phase:
- Fill: accepts a programmed number of bytes from a producer over a valid/ready handshake.
- Hold: retains the bytes until a drain command arrives.
- Drain: shifts the bytes out oldest-first to a consumer over a valid/ready handshake.

It sits between the pin-level input bus and the output bus of the top-level tile and replaces free-running shift behaviour with explicit sequencing.

Parameters:
DEPTH, 10, number of buffer entries (2..15)
WIDTH, 8, bits per entry

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cmd_fill  input  1  single-cycle request to start a fill; honoured only in IDLE
fill_len  input  4  number of bytes to fill, sampled with cmd_fill
cmd_drain  input  1  single-cycle request to start a drain; honoured only in HOLD
abort  input  1  return to IDLE and discard buffer contents
in_data  input  WIDTH  producer data
in_valid  input  1  producer data valid
in_ready  output  1  controller accepts in_data
out_data  output  WIDTH  consumer data (buffer entry 0)
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
count  output  4  entries currently held
state  output  2  IDLE=0, FILL=1, HOLD=2, DRAIN=3
done  output  1  one-cycle pulse when a fill or drain completes
err  output  1  one-cycle pulse on a rejected command

Behaviour:
Reset:
- reset is synchronous, active-high, clock clk.
- Reset sets state=IDLE, count=0, target length=0, all buffer entries=0, done=0, err=0.
- Consequently in_ready=0, out_valid=0 and out_data=0 after reset.
- Reset has priority over every other input, including mid-fill and mid-drain.

Outputs:
- in_ready = (state==FILL); combinational from state only.
- out_valid = (state==DRAIN) and (count!=0).
- out_data = buffer entry 0, driven directly from the register.
- Handshakes complete on any cycle with valid and ready both high. No combinational path from in_valid to in_ready, or from out_ready to out_valid.

IDLE:
- cmd_fill with 1<=fill_len<=DEPTH: latch fill_len as target, set count=0, go to FILL next cycle.
- cmd_fill with fill_len=0 or fill_len>DEPTH: pulse err next cycle, stay in IDLE.
- cmd_drain in IDLE: pulse err, stay in IDLE.

FILL:
- Each accepted byte is written to entry[count]; count increments.
- The cycle that accepts the byte bringing count to the target: go to HOLD next cycle and pulse done in that same next cycle.
- Latency: the final byte is visible in count and state=HOLD one cycle after its handshake.

HOLD:
- Contents and count are frozen.
- cmd_drain: go to DRAIN next cycle.
- cmd_fill in HOLD: pulse err, stay in HOLD.

DRAIN:
- On each out handshake, every entry shifts down by one (entry[i] <= entry[i+1]), entry[DEPTH-1] <= 0, and count decrements.
- The handshake that brings count to 0: go to IDLE next cycle and pulse done.
- Output order equals fill order.

Commands outside their accepting state:
- Any cmd_fill or cmd_drain arriving in FILL or DRAIN is ignored and pulses err.

abort:
- In any non-IDLE state: go to IDLE next cycle, count=0, all entries cleared, no done pulse.
- abort has priority over a same-cycle handshake and over a same-cycle command.
- abort in IDLE has no effect.

Simultaneous commands:
- cmd_fill and cmd_drain asserted together in IDLE: cmd_fill is honoured and err does not pulse.
- In HOLD the same combination: cmd_drain is honoured and err does not pulse.

Pulse widths:
- done and err are registered and exactly one cycle wide.

Widths:
- count is 4 bits and saturates at DEPTH by construction.
- fill_len is compared unsigned.

Test Plan:
1. Reset, then cmd_fill fill_len=3. Push 0x11, 0x22, 0x33 with in_valid held high -> in_ready high for 3 cycles; state=HOLD, count=3, done pulses once. Then cmd_drain with out_ready=1 -> out_data sequence 0x11, 0x22, 0x33 on consecutive cycles; done pulses; state=IDLE, count=0.
2. Full depth: fill_len=10 with bytes 0x01..0x0A, drain with out_ready toggling 1,0,1,0 -> ten bytes emitted in order; out_data stable and out_valid high while out_ready=0.
3. Rejected commands: each of the following pulses err exactly once and leaves state=IDLE, count=0:
   - cmd_fill fill_len=0
   - cmd_fill fill_len=11
   - cmd_drain in IDLE
4. Abort mid-fill: fill_len=5, accept 2 bytes, then abort in the same cycle as a third handshake -> IDLE next cycle, count=0, third byte not stored, no done pulse.
5. Reset mid-drain: fill 4 bytes, drain 1, assert reset -> next cycle state=IDLE, out_valid=0, out_data=0, count=0.
6. Producer stalls: fill_len=2 with in_valid gaps of 3 cycles -> count increments only on handshakes; HOLD is reached one cycle after the second accept.
